// File: rtl/pe_os_banked_if.sv
// pe_os_banked_if: systolic operand, drain-request and result signals of one PE.
interface pe_os_banked_if #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_ACC = 4
);
   localparam int SEL_W = $clog2(NUM_ACC);
   logic pulse_systolic_module;
   logic fwd_in_valid;
   logic [DATA_WIDTH-1:0] fwd_in;
   logic down_in_valid;
   logic [DATA_WIDTH-1:0] down_in;
   logic [SEL_W-1:0] acc_sel;
   logic fwd_out_valid;
   logic [DATA_WIDTH-1:0] fwd_out;
   logic down_out_valid;
   logic [DATA_WIDTH-1:0] down_out;
   logic post_req;
   logic [SEL_W-1:0] post_sel;
   logic [DATA_WIDTH-1:0] bias;
   logic [1:0] activation;
   logic [DATA_WIDTH-1:0] alpha;
   logic post_busy;
   logic result_valid;
   logic result_ready;
   logic [DATA_WIDTH-1:0] result_data;
   logic [SEL_W-1:0] result_sel;
   logic collision;
   logic [31:0] debug_update_count;
   modport slave (
      input pulse_systolic_module, fwd_in_valid, fwd_in, down_in_valid, down_in, acc_sel,
            post_req, post_sel, bias, activation, alpha, result_ready,
      output fwd_out_valid, fwd_out, down_out_valid, down_out, post_busy, result_valid,
             result_data, result_sel, collision, debug_update_count
   );
   modport master (
      output pulse_systolic_module, fwd_in_valid, fwd_in, down_in_valid, down_in, acc_sel,
             post_req, post_sel, bias, activation, alpha, result_ready,
      input fwd_out_valid, fwd_out, down_out_valid, down_out, post_busy, result_valid,
            result_data, result_sel, collision, debug_update_count
   );
endinterface

// File: rtl/pe_os_banked.sv
// pe_os_banked: output-stationary systolic PE with banked accumulators and a bias/act/quant drain pipeline.
// Defining PE_DEBUG_COUNTERS_EN builds a 32-bit count of applied MAC updates.
module pe_os_banked #(
   parameter int DATA_WIDTH = 16,
   parameter int ACC_WIDTH = 40,
   parameter int FRAC_BITS = 8,
   parameter int NUM_ACC = 4
) (
   input logic core_clk,
   input logic resetn,
   pe_os_banked_if.slave bus
);
   localparam int SEL_W = $clog2(NUM_ACC);
   localparam int LW = ACC_WIDTH + DATA_WIDTH;
   localparam logic signed [ACC_WIDTH-1:0] SMAX = ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_WIDTH-1:0] SMIN = ~SMAX;
   typedef enum logic [2:0] {IDLE, BIAS, ACT, QUANT, OUT} state_t;
   state_t state_q, state_d;
   logic signed [ACC_WIDTH-1:0] bank_q [NUM_ACC];
   logic signed [ACC_WIDTH-1:0] bank_d [NUM_ACC];
   logic [SEL_W-1:0] sel_q, sel_d;
   logic signed [DATA_WIDTH-1:0] bias_q, bias_d, alpha_q, alpha_d, res_q, res_d;
   logic [1:0] act_q, act_d;
   logic signed [ACC_WIDTH-1:0] t_q, t_d, q_sh;
   logic signed [2*DATA_WIDTH-1:0] prod;
   logic signed [LW-1:0] leaky;
   logic update, drop, apply, coll_q;
   logic fwd_v_q, down_v_q;
   logic [DATA_WIDTH-1:0] fwd_q, down_q;
   assign prod = $signed(bus.fwd_in) * $signed(bus.down_in);
   assign update = bus.pulse_systolic_module & bus.fwd_in_valid & bus.down_in_valid;
   // A MAC aimed at the bank being drained would corrupt the result, so it is discarded.
   assign drop = state_q != IDLE && bus.acc_sel == sel_q;
   assign apply = update && !drop;
   assign leaky = LW'(t_q) * LW'(alpha_q);
   assign q_sh = t_q >>> FRAC_BITS;
   always_comb begin
      state_d = state_q;
      sel_d = sel_q;
      bias_d = bias_q;
      alpha_d = alpha_q;
      act_d = act_q;
      t_d = t_q;
      res_d = res_q;
      bank_d = bank_q;
      if (apply) bank_d[bus.acc_sel] = bank_q[bus.acc_sel] + ACC_WIDTH'(prod);
      case (state_q)
         IDLE: if (bus.post_req) begin
            state_d = BIAS;
            sel_d = bus.post_sel;
            bias_d = bus.bias;
            alpha_d = bus.alpha;
            act_d = bus.activation;
         end
         BIAS: begin
            t_d = bank_q[sel_q] + (ACC_WIDTH'(bias_q) <<< FRAC_BITS);
            state_d = ACT;
         end
         ACT: begin
            t_d = (act_q == 2'd1 && t_q < 0) ? '0
                : (act_q == 2'd2 && t_q < 0) ? ACC_WIDTH'(leaky >>> FRAC_BITS) : t_q;
            state_d = QUANT;
         end
         QUANT: begin
            res_d = q_sh > SMAX ? DATA_WIDTH'(SMAX) : q_sh < SMIN ? DATA_WIDTH'(SMIN) : DATA_WIDTH'(q_sh);
            state_d = OUT;
         end
         OUT: if (bus.result_ready) begin
            bank_d[sel_q] = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         for (int i = 0; i < NUM_ACC; i++) bank_q[i] <= '0;
         sel_q <= '0;
         bias_q <= '0;
         alpha_q <= '0;
         act_q <= '0;
         t_q <= '0;
         res_q <= '0;
         coll_q <= 1'b0;
         fwd_v_q <= 1'b0;
         down_v_q <= 1'b0;
         fwd_q <= '0;
         down_q <= '0;
      end else begin
         state_q <= state_d;
         bank_q <= bank_d;
         sel_q <= sel_d;
         bias_q <= bias_d;
         alpha_q <= alpha_d;
         act_q <= act_d;
         t_q <= t_d;
         res_q <= res_d;
         coll_q <= coll_q | (update & drop);
         if (bus.pulse_systolic_module) begin
            fwd_v_q <= bus.fwd_in_valid;
            down_v_q <= bus.down_in_valid;
            fwd_q <= bus.fwd_in;
            down_q <= bus.down_in;
         end
      end
   end
   assign bus.fwd_out_valid = fwd_v_q;
   assign bus.fwd_out = fwd_q;
   assign bus.down_out_valid = down_v_q;
   assign bus.down_out = down_q;
   assign bus.post_busy = state_q != IDLE;
   assign bus.result_valid = state_q == OUT;
   assign bus.result_data = res_q;
   assign bus.result_sel = sel_q;
   assign bus.collision = coll_q;
`ifdef PE_DEBUG_COUNTERS_EN
   logic [31:0] cnt_q;
   always_ff @(posedge core_clk or negedge resetn) begin
      if (!resetn) cnt_q <= '0;
      else cnt_q <= cnt_q + {31'd0, apply};
   end
   assign bus.debug_update_count = cnt_q;
`else
   assign bus.debug_update_count = '0;
`endif
endmodule

// File: tb/tb_pe_os_banked.sv
// tb_pe_os_banked: directed and randomized checks of pe_os_banked against a cycle-level arithmetic model.
module tb_pe_os_banked;
   logic core_clk = 1'b0;
   logic resetn = 1'b0;
   bit checking = 1'b0;
   int n_checks = 0;
   int n_fail = 0;
   pe_os_banked_if #(.DATA_WIDTH(16), .NUM_ACC(4)) bus ();
   pe_os_banked #(.DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8), .NUM_ACC(4)) dut (
      .core_clk(core_clk), .resetn(resetn), .bus(bus));
   always #5 core_clk = ~core_clk;

   // Model: banks as 40-bit values held in longint, drain tracked as a cycle phase 0..4.
   longint mbank [4];
   int phase;
   int msel, mact;
   longint mbias, malpha, exp_res;
   bit fwd_v_e, down_v_e, coll_e;
   longint fwd_e, down_e;
   bit [31:0] cnt_e;

   function automatic longint w40(longint x);
      return (x <<< 24) >>> 24;
   endfunction

   function automatic longint post(longint acc, longint b, int a, longint al);
      longint t, r;
      t = w40(acc + b * 256);
      if (a == 1 && t < 0) t = 0;
      else if (a == 2 && t < 0) t = w40((t * al) >>> 8);
      r = t >>> 8;
      return r > 32767 ? 32767 : r < -32768 ? -32768 : r;
   endfunction

   task automatic chk(input string nm, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   always @(posedge core_clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 4; i++) mbank[i] = 0;
         phase = 0; msel = 0; mact = 0; mbias = 0; malpha = 0; exp_res = 0;
         fwd_v_e = 0; down_v_e = 0; coll_e = 0; fwd_e = 0; down_e = 0; cnt_e = 0;
      end else begin
         bit upd;
         int s;
         upd = bus.pulse_systolic_module && bus.fwd_in_valid && bus.down_in_valid;
         s = int'(bus.acc_sel);
         if (upd && phase != 0 && s == msel) coll_e = 1;
         else if (upd) begin
            mbank[s] = w40(mbank[s] + longint'($signed(bus.fwd_in)) * longint'($signed(bus.down_in)));
            cnt_e++;
         end
         if (bus.pulse_systolic_module) begin
            fwd_v_e = bus.fwd_in_valid; down_v_e = bus.down_in_valid;
            fwd_e = bus.fwd_in; down_e = bus.down_in;
         end
         case (phase)
            0: if (bus.post_req) begin
               msel = int'(bus.post_sel); mact = int'(bus.activation);
               mbias = longint'($signed(bus.bias)); malpha = longint'($signed(bus.alpha));
               phase = 1;
            end
            1: begin exp_res = post(mbank[msel], mbias, mact, malpha); phase = 2; end
            2, 3: phase++;
            default: if (bus.result_ready) begin mbank[msel] = 0; phase = 0; end
         endcase
      end
   end

   always @(negedge core_clk) if (checking && resetn) begin
      chk("fwd_out_valid", bus.fwd_out_valid, fwd_v_e);
      chk("fwd_out", bus.fwd_out, fwd_e);
      chk("down_out_valid", bus.down_out_valid, down_v_e);
      chk("down_out", bus.down_out, down_e);
      chk("post_busy", bus.post_busy, phase != 0);
      chk("result_valid", bus.result_valid, phase == 4);
      if (phase == 4) begin
         chk("result_data", longint'($signed(bus.result_data)), exp_res);
         chk("result_sel", bus.result_sel, msel);
      end
      chk("collision", bus.collision, coll_e);
`ifdef PE_DEBUG_COUNTERS_EN
      chk("debug_count", bus.debug_update_count, cnt_e);
`else
      chk("debug_count", bus.debug_update_count, 0);
`endif
   end

   task automatic idle_in();
      bus.pulse_systolic_module = 0; bus.fwd_in_valid = 0; bus.down_in_valid = 0;
      bus.fwd_in = 0; bus.down_in = 0; bus.acc_sel = 0; bus.post_req = 0; bus.post_sel = 0;
      bus.bias = 0; bus.activation = 0; bus.alpha = 0; bus.result_ready = 0;
   endtask

   task automatic mac(input int s, input int a, input int b, input bit fv);
      bus.pulse_systolic_module = 1; bus.fwd_in_valid = fv; bus.down_in_valid = 1;
      bus.acc_sel = 2'(s); bus.fwd_in = 16'(a); bus.down_in = 16'(b);
      @(negedge core_clk);
      bus.pulse_systolic_module = 0; bus.fwd_in_valid = 0; bus.down_in_valid = 0;
   endtask

   task automatic request(input int s, input int b, input int a, input int al);
      bus.post_req = 1; bus.post_sel = 2'(s); bus.bias = 16'(b);
      bus.activation = 2'(a); bus.alpha = 16'(al);
      @(negedge core_clk);
      bus.post_req = 0;
   endtask

   task automatic wait_valid(input string nm, output int lat);
      lat = 1;
      while (!bus.result_valid && lat < 20) begin @(negedge core_clk); lat++; end
      chk({nm, "_latency"}, lat, 4);
   endtask

   task automatic drain(input int s, input int b, input int a, input int al, input longint lit, input string nm);
      int lat;
      request(s, b, a, al);
      wait_valid(nm, lat);
      chk({nm, "_data"}, longint'($signed(bus.result_data)), lit);
      chk({nm, "_model"}, exp_res, lit);
      chk({nm, "_sel"}, bus.result_sel, s);
      bus.result_ready = 1;
      @(negedge core_clk);
      bus.result_ready = 0;
   endtask

   task automatic outputs_zero(input string nm);
      chk({nm, "_valids"}, {bus.fwd_out_valid, bus.down_out_valid, bus.result_valid, bus.post_busy, bus.collision}, 0);
      chk({nm, "_data"}, {bus.fwd_out, bus.down_out, bus.result_data, bus.result_sel}, 0);
      chk({nm, "_dbg"}, bus.debug_update_count, 0);
   endtask

   initial begin
      int lat;
      logic [15:0] held;
      idle_in();
      @(negedge core_clk);
      #1 outputs_zero("reset");
      @(negedge core_clk);
      resetn = 1;
      checking = 1;
      @(negedge core_clk);
      // Basic MAC: 2.0 + 2.0 - 1.0 = 3.0
      mac(0, 256, 512, 1); mac(0, 128, 1024, 1); mac(0, -256, 256, 1);
      drain(0, 0, 0, 0, 768, "basic");
      drain(0, 0, 0, 0, 0, "basic_cleared");
      // Bank interleave, plus a pulse with fwd_in_valid low
      for (int i = 0; i < 4; i++) mac(i % 2, 256, 256, 1);
      mac(0, 256, 256, 0);
      drain(1, 0, 0, 0, 512, "interleave_b1");
      drain(0, 0, 0, 0, 512, "interleave_b0");
      // Bias and activation: acc -2.0, bias 0.5
      mac(0, -512, 256, 1); drain(0, 128, 1, 0, 0, "relu");
      mac(0, -512, 256, 1); drain(0, 128, 2, 64, -96, "leaky");
      mac(0, -512, 256, 1); drain(0, 128, 0, 0, -384, "none");
      // Saturation
      for (int i = 0; i < 200; i++) mac(0, 32512, 32512, 1);
      drain(0, 0, 0, 0, 32767, "sat_pos");
      for (int i = 0; i < 200; i++) mac(1, -32512, 32512, 1);
      drain(1, 0, 0, 0, -32768, "sat_neg");
      // Backpressure, ignored request, collision and MAC to another bank
      mac(2, 256, 256, 1);
      request(2, 0, 0, 0);
      wait_valid("bp", lat);
      held = bus.result_data;
      chk("bp_first", longint'($signed(held)), 256);
      for (int i = 0; i < 10; i++) begin
         if (i == 2) begin bus.post_req = 1; bus.post_sel = 3; end
         if (i == 4) mac(2, 512, 512, 1);
         else if (i == 6) mac(3, 256, 512, 1);
         else @(negedge core_clk);
         bus.post_req = 0;
         chk("bp_valid_held", bus.result_valid, 1);
         chk("bp_data_held", bus.result_data, held);
      end
      chk("bp_collision", bus.collision, 1);
      bus.result_ready = 1;
      @(negedge core_clk);
      bus.result_ready = 0;
      drain(3, 0, 0, 0, 512, "other_bank");
      drain(2, 0, 0, 0, 0, "bp_cleared");
      // Reset while in ACT
      mac(1, 256, 256, 1);
      request(1, 0, 0, 0);
      @(negedge core_clk);
      resetn = 0;
      #1 outputs_zero("mid_reset");
      @(negedge core_clk);
      @(negedge core_clk);
      resetn = 1;
      @(negedge core_clk);
      drain(1, 0, 0, 0, 0, "after_reset");
      mac(1, 256, 256, 1);
      drain(1, 64, 0, 0, 320, "after_reset_mac");
      // Randomized traffic checked cycle by cycle against the model
      for (int i = 0; i < 1500; i++) begin
         bus.pulse_systolic_module = ($urandom % 4) != 0;
         bus.fwd_in_valid = ($urandom % 4) != 0;
         bus.down_in_valid = ($urandom % 4) != 0;
         bus.fwd_in = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
         bus.down_in = ($urandom % 2) ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
         bus.acc_sel = 2'($urandom);
         bus.post_req = ($urandom % 8) == 0;
         bus.post_sel = 2'($urandom);
         bus.bias = 16'($urandom);
         bus.activation = 2'($urandom);
         bus.alpha = 16'($urandom);
         bus.result_ready = 1'($urandom);
         @(negedge core_clk);
      end
      idle_in();
      @(negedge core_clk);
      checking = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/pe_os_banked.md
Name: pe_os_banked

Overview:
- Fixed-point output-stationary systolic processing element with NUM_ACC independent accumulator banks.
- Tiles can interleave accumulation across banks.
- A bank is drained through a pipelined post-processing path: bias add, then activation, then requantise/saturate, then a valid/ready result handshake. The bank is auto-cleared on acceptance.
- Sits in the systolic array grid. Forwards operands right and down on each systolic pulse.

Parameters:
- DATA_WIDTH, 16: operand, bias, alpha and result width (signed two's complement).
- ACC_WIDTH, 40: accumulator width (signed). Must be ≥ 2*DATA_WIDTH.
- FRAC_BITS, 8: fractional bits of operands, bias, alpha and result. Products carry 2*FRAC_BITS fractional bits.
- NUM_ACC, 4: number of accumulator banks, ≥ 2. SEL_W = $clog2(NUM_ACC).

Ports:
- core_clk, in, 1: clock.
- resetn, in, 1: reset, asynchronous, active-low.
- pulse_systolic_module, in, 1: systolic advance strobe.
- fwd_in_valid, in, 1 / fwd_in, in, DATA_WIDTH: operand from the left.
- down_in_valid, in, 1 / down_in, in, DATA_WIDTH: operand from above.
- acc_sel, in, SEL_W: target bank for the MAC on this pulse.
- fwd_out_valid, out, 1 / fwd_out, out, DATA_WIDTH: registered operand to the right.
- down_out_valid, out, 1 / down_out, out, DATA_WIDTH: registered operand downward.
- post_req, in, 1 / post_sel, in, SEL_W: request drain of bank post_sel.
- bias, in, DATA_WIDTH: bias, sampled at post_req acceptance.
- activation, in, 2: 0 none, 1 ReLU, 2 leaky ReLU, 3 reserved (treated as none). Sampled at acceptance.
- alpha, in, DATA_WIDTH: leaky slope. Sampled at acceptance.
- post_busy, out, 1: post FSM not IDLE.
- result_valid, out, 1 / result_ready, in, 1: result handshake.
- result_data, out, DATA_WIDTH: requantised result.
- result_sel, out, SEL_W: bank the result came from.
- collision, out, 1: sticky; a MAC targeted the bank being drained.
- debug_update_count, out, 32: see Optional Feature.

Behaviour:
- Reset values: all banks 0. All outputs 0, including valids, post_busy and collision. FSM in IDLE.
- Forwarding: on a cycle with pulse_systolic_module, register fwd_in/down_in and their valids to the *_out ports. Otherwise hold. Latency is 1 pulse.
- MAC: update = pulse && fwd_in_valid && down_in_valid.
  - On update: bank[acc_sel] += sext(fwd_in*down_in) (signed, 2*DATA_WIDTH bits, sign-extended to ACC_WIDTH).
  - Wraps modulo 2^ACC_WIDTH.
  - Other banks are unchanged.
- FSM states: IDLE, BIAS, ACT, QUANT, OUT.
- IDLE: post_req accepted only in IDLE.
  - Latch post_sel, bias, activation and alpha.
  - Go to BIAS. post_busy rises the next cycle.
  - post_req outside IDLE is ignored (not queued).
- BIAS:
  - t = bank[sel] + (sext(bias) <<< FRAC_BITS). Wrap.
  - Go to ACT.
- ACT:
  - none: t.
  - ReLU: t<0 ? 0 : t.
  - Leaky: t<0 ? (t*alpha)>>>FRAC_BITS : t, truncated to ACC_WIDTH.
  - Go to QUANT.
- QUANT:
  - r = t>>>FRAC_BITS (arithmetic; floor rounding).
  - Saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - Go to OUT.
- OUT: result_valid=1, with result_data and result_sel stable until handshake.
  - On result_valid && result_ready: clear bank[sel] to 0, drop result_valid and return to IDLE in the same cycle.
  - result_valid therefore first asserts 4 cycles after the acceptance cycle.
- Collision: a MAC with acc_sel == latched sel while FSM ≠ IDLE is dropped (bank unchanged) and sets collision until reset. MACs to other banks proceed normally during a drain.
- Same-cycle MAC and accept on the same bank in IDLE: MAC is applied, and the BIAS stage reads the updated value.
- Reset mid-drain: FSM returns to IDLE, banks clear and the result is lost.

Optional Feature:
- Macro: PE_DEBUG_COUNTERS_EN.
- Defined: debug_update_count holds a 32-bit count of applied MAC updates (dropped collisions not counted), reset to 0. It wraps at 2^32.
- Undefined: no counter logic is built, and debug_update_count is tied to 0.

Test Plan:
- Basic MAC: 3 pulses to bank 0 with (1.0,2.0),(0.5,4.0),(-1.0,1.0) in Q8 (256,512),(128,1024),(-256,256); then drain with bias=0, act=none → result_data=768 (3.0), result_sel=0; bank 0 reads 0 afterwards.
- Bank interleave: alternate acc_sel 0/1 with (256,256) for 4 pulses, drain bank 1 → 512; then drain bank 0 → 512. A pulse with fwd_in_valid=0 leaves both banks unchanged.
- Bias + activation: acc=-2.0, bias=0.5:
  - act=ReLU → 0.
  - act=leaky with alpha=0.25 (64) → -96 (-0.375).
  - act=none → -384.
- Saturation: accumulate 200 × (127.0, 127.0) in Q8 (32512,32512) → result 32767; negative equivalent → -32768.
- Backpressure/collision: hold result_ready=0 for 10 cycles → result_valid and data stable, and a second post_req is ignored. A MAC to the draining bank sets collision and leaves the result unchanged. A MAC to another bank still applies.
- Reset mid-drain: assert resetn=0 while in ACT → all outputs 0 and FSM in IDLE. A post_req after release proceeds normally.
